upsample2x_nn_axis: RTL and testbench

//  Nearest-neighbour 2x upsampler feeding the conv2d stage's s_axis input (GAN generator up-block).

---
 rtl/upsample2x_nn_axis_pkg.sv | 14 +
 rtl/upsample2x_nn_axis_line_buffer.sv | 27 ++
 rtl/upsample2x_nn_axis.sv | 174 +++++++++++++++++
 tb/tb_upsample2x_nn_axis.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample2x_nn_axis_pkg.sv
// Shared defaults and FSM state encoding for the 2x nearest-neighbour upsampler.
package upsample2x_nn_axis_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_MAX_IN = 64;
    localparam int unsigned DEF_COL_W  = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_REPLAY = 2'd2
    } up_state_t;

endpackage

// File: rtl/upsample2x_nn_axis_line_buffer.sv
// One-row line buffer: synchronous write, combinational read (distributed RAM).
module upsample_line_buffer
    import upsample2x_nn_axis_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MAX_IN = DEF_MAX_IN,
    parameter int unsigned ADDR_W = $clog2(MAX_IN)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MAX_IN];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/upsample2x_nn_axis.sv
// Nearest-neighbour 2x upsampler on AXI-Stream: each pixel emitted twice, each row replayed once.
module upsample2x_nn_axis
    import upsample2x_nn_axis_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned MAX_IN = DEF_MAX_IN,
    parameter int unsigned COL_W  = DEF_COL_W
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [7:0]        in_size,
    input  logic [8:0]        num_channels,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              framing_err
);

    localparam int unsigned ADDR_W = $clog2(MAX_IN);

    up_state_t         r_state;
    logic              r_dup;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  r_row;
    logic [8:0]        r_chan;
    logic [7:0]        r_last_idx;
    logic [8:0]        r_chan_last;
    logic [DATA_W-1:0] r_m_tdata;
    logic              r_m_tvalid;
    logic              r_m_tlast;
    logic              r_framing_err;

    logic              w_slot_free;
    logic              w_s_ready;
    logic              w_s_hs;
    logic              w_last_col;
    logic              w_last_row;
    logic              w_last_chan;
    logic              w_last_in;
    logic [DATA_W-1:0] w_rd_data;

    assign w_slot_free = !r_m_tvalid || m_axis_tready;
    assign w_s_ready   = (r_state == S_FILL) && !r_dup && w_slot_free;
    assign w_s_hs      = w_s_ready && s_axis_tvalid;
    assign w_last_col  = (8'(r_col) == r_last_idx);
    assign w_last_row  = (8'(r_row) == r_last_idx);
    assign w_last_chan = (r_chan == r_chan_last);
    assign w_last_in   = w_last_col && w_last_row && w_last_chan;

    upsample_line_buffer #(
        .DATA_W (DATA_W),
        .MAX_IN (MAX_IN),
        .ADDR_W (ADDR_W)
    ) u_lbuf (
        .clk     (clk),
        .i_we    (w_s_hs),
        .i_waddr (r_col[ADDR_W-1:0]),
        .i_wdata (s_axis_tdata),
        .i_raddr (r_col[ADDR_W-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_dup         <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_chan        <= '0;
            r_last_idx    <= '0;
            r_chan_last   <= '0;
            r_m_tdata     <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tlast     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            if (w_s_hs && (s_axis_tlast != w_last_in)) begin
                r_framing_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_last_idx  <= in_size - 8'd1;
                    r_chan_last <= num_channels - 9'd1;
                    r_dup       <= 1'b0;
                    r_col       <= '0;
                    r_row       <= '0;
                    r_chan      <= '0;
                    if (m_axis_tready) begin
                        r_m_tvalid <= 1'b0;
                        r_m_tlast  <= 1'b0;
                    end
                    if (s_axis_tvalid) begin
                        r_state <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (!r_dup) begin
                        if (w_s_hs) begin
                            r_m_tdata  <= s_axis_tdata;
                            r_m_tvalid <= 1'b1;
                            r_m_tlast  <= 1'b0;
                            r_dup      <= 1'b1;
                        end else if (m_axis_tready) begin
                            r_m_tvalid <= 1'b0;
                        end
                    end else if (w_slot_free) begin
                        // second copy: tdata register already holds the pixel
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= 1'b0;
                        r_dup      <= 1'b0;
                        if (w_last_col) begin
                            r_col   <= '0;
                            r_state <= S_REPLAY;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end

                S_REPLAY: begin
                    // hold here until the tlast beat leaves, then return to idle
                    if (r_m_tvalid && r_m_tlast) begin
                        if (m_axis_tready) begin
                            r_m_tvalid <= 1'b0;
                            r_m_tlast  <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else if (w_slot_free) begin
                        r_m_tdata  <= w_rd_data;
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= r_dup && w_last_in;
                        r_dup      <= ~r_dup;
                        if (r_dup) begin
                            if (w_last_col) begin
                                r_col <= '0;
                                if (w_last_row) begin
                                    r_row  <= '0;
                                    r_chan <= w_last_chan ? 9'd0 : r_chan + 9'd1;
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                                if (!(w_last_row && w_last_chan)) begin
                                    r_state <= S_FILL;
                                end
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign busy          = (r_state != S_IDLE);
    assign framing_err   = r_framing_err;

endmodule

// File: tb/tb_upsample2x_nn_axis.sv
// Scoreboard bench for upsample2x_nn_axis: directed frames, tready throttling, gaps, framing, reset.
module tb_upsample2x_nn_axis;
    import upsample2x_nn_axis_pkg::*;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  in_size = 8'd2;
    logic [8:0]  num_channels = 9'd1;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic        busy;
    logic        ferr;

    always #5 clk = ~clk;

    upsample2x_nn_axis #(
        .DATA_W (16),
        .MAX_IN (64),
        .COL_W  (7)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .in_size       (in_size),
        .num_channels  (num_channels),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .framing_err   (ferr)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    int          n_checks = 0;
    int          n_pass = 0;
    beat_t       exp_q[$];
    logic [15:0] pix[$];
    bit          mon_en = 1'b1;
    bit          rnd_ready = 1'b0;
    bit          gaps = 1'b0;

    logic [15:0] t1_exp [16] = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd1, 16'd1, 16'd2, 16'd2,
                                 16'd3, 16'd3, 16'd4, 16'd4, 16'd3, 16'd3, 16'd4, 16'd4};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // output ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: pops scoreboard on each handshake, checks AXI hold rule and REPLAY stall
    beat_t       mon_b;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic        prev_l;
    initial begin
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(m_tvalid), 32'd1);
                    chk("hold_data", 32'(m_tdata), 32'(prev_d));
                    chk("hold_last", 32'(m_tlast), 32'(prev_l));
                end
                prev_stall = m_tvalid && !m_tready;
                prev_d = m_tdata;
                prev_l = m_tlast;
                if (dut.r_state == S_REPLAY) chk("sready_replay", 32'(s_tready), 32'd0);
                if (mon_en && m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'(m_tdata), 32'hDEAD);
                    end else begin
                        mon_b = exp_q.pop_front();
                        chk("out_data", 32'(m_tdata), 32'(mon_b.d));
                        chk("out_last", 32'(m_tlast), 32'(mon_b.l));
                    end
                end
            end
        end
    end

    task automatic push_model(input int n, input int ch);
        for (int c = 0; c < ch; c++)
            for (int r = 0; r < n; r++)
                for (int cp = 0; cp < 2; cp++)
                    for (int x = 0; x < n; x++)
                        for (int d = 0; d < 2; d++) begin
                            beat_t b;
                            b.d = pix[c*n*n + r*n + x];
                            b.l = (c == ch-1) && (r == n-1) && (cp == 1) && (x == n-1) && (d == 1);
                            exp_q.push_back(b);
                        end
    endtask

    task automatic send(input int cnt, input int tlast_at);
        for (int i = 0; i < cnt; i++) begin
            int t;
            if (gaps && (i % 3 == 1)) begin
                s_tvalid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = pix[i];
            s_tlast  = (i == tlast_at);
            t = 0;
            @(negedge clk);
            while (!s_tready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (t >= 500) begin
                chk("send_timeout", 32'(t), 32'd0);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("valid_idle", 32'(m_tvalid), 32'd0);
    endtask

    task automatic run_frame(input int n, input int ch, input bit use_model, input int tlast_at);
        in_size      = 8'(n);
        num_channels = 9'(ch);
        @(posedge clk);
        #1;
        if (use_model) push_model(n, ch);
        send(n*n*ch, tlast_at);
        wait_drain();
    endtask

    task automatic push_t1();
        pix.delete();
        for (int i = 1; i <= 4; i++) pix.push_back(16'(i));
        for (int i = 0; i < 16; i++) begin
            beat_t b;
            b.d = t1_exp[i];
            b.l = (i == 15);
            exp_q.push_back(b);
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // 2x2, one channel, hand table
        push_t1();
        run_frame(2, 1, 1'b0, 3);

        // 4x4, three channels, ramp
        pix.delete();
        for (int i = 0; i < 48; i++) pix.push_back(16'(i));
        run_frame(4, 3, 1'b1, 47);

        // 8x8 with random output backpressure
        pix.delete();
        for (int i = 0; i < 64; i++) pix.push_back(16'h1000 + 16'(i*7));
        rnd_ready = 1'b1;
        run_frame(8, 1, 1'b1, 63);
        rnd_ready = 1'b0;

        // input valid gaps during fill
        pix.delete();
        for (int i = 0; i < 32; i++) pix.push_back(16'hA000 + 16'(i));
        gaps = 1'b1;
        run_frame(4, 2, 1'b1, 31);
        gaps = 1'b0;
        chk("ferr_clean", 32'(ferr), 32'd0);

        // tlast on pixel 3 of a 16-pixel frame
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(16'h5000 + 16'(i));
        run_frame(4, 1, 1'b1, 2);
        chk("ferr_set", 32'(ferr), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("ferr_sticky", 32'(ferr), 32'd1);

        // reset in the middle of a row replay
        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(16'h0100 + 16'(i));
        mon_en       = 1'b0;
        in_size      = 8'd4;
        num_channels = 9'd1;
        @(posedge clk);
        #1;
        send(4, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("in_replay", 32'(dut.r_state == S_REPLAY), 32'd1);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ferr", 32'(ferr), 32'd0);
        aresetn = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        push_t1();
        run_frame(2, 1, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
